// File: rtl/mul6_pkg.sv
// Shared widths and FSM state encoding for the 6x6 shift-and-add multiplier.
package mul6_pkg;

   localparam int unsigned WIDTH  = 6;
   localparam int unsigned PROD_W = 12;
   localparam int unsigned CNT_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/mul6_shift_add_rca6.sv
// 6-bit ripple-carry adder (RCA6); purely combinational sum and carry-out.
module rca6
   import mul6_pkg::*;
(
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_cin,
   output logic [WIDTH-1:0] o_sum_c,
   output logic             o_cout_c
);

   logic [WIDTH:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar i = 0; i < int'(WIDTH); i++) begin : g_fa
      assign o_sum_c[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      assign w_c[i+1]    = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
   end

   assign o_cout_c = w_c[WIDTH];

endmodule

// File: rtl/mul6_shift_add.sv
// Sequential 6x6 unsigned shift-and-add multiplier with valid/ready on both sides.
// One RCA6 add per RUN cycle; product is the live P register.
module mul6_shift_add
   import mul6_pkg::*;
#(
   parameter int unsigned P_WIDTH = WIDTH,
   parameter int unsigned P_CNT_W = CNT_W
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [P_WIDTH-1:0]     a,
   input  logic [P_WIDTH-1:0]     b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2*P_WIDTH-1:0]   product
);

   if (P_WIDTH != WIDTH || P_CNT_W != CNT_W) begin : g_bad_param
      $error("mul6_shift_add: width is fixed by RCA6 (WIDTH=6, CNT_W=3)");
   end

   state_e               r_state,  w_state_nxt;
   logic [WIDTH-1:0]     r_mcand,  w_mcand_nxt;
   logic [PROD_W-1:0]    r_p,      w_p_nxt;
   logic [CNT_W-1:0]     r_cnt,    w_cnt_nxt;
   logic                 r_in_ready;
   logic                 r_out_valid;

   logic [WIDTH-1:0]     w_add_b;
   logic [WIDTH-1:0]     w_sum;
   logic                 w_cout;

   // Adding zero when P[0]=0 yields {0, acc_hi}, so one adder covers both cases
   assign w_add_b = r_p[0] ? r_mcand : WIDTH'(0);

   rca6 u_add (
      .i_a      (r_p[PROD_W-1:WIDTH]),
      .i_b      (w_add_b),
      .i_cin    (1'b0),
      .o_sum_c  (w_sum),
      .o_cout_c (w_cout)
   );

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_mcand     <= '0;
         r_p         <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_mcand     <= w_mcand_nxt;
         r_p         <= w_p_nxt;
         r_cnt       <= w_cnt_nxt;
         r_in_ready  <= (w_state_nxt == ST_IDLE);
         r_out_valid <= (w_state_nxt == ST_DONE);
      end
   end

   // Next-state and datapath update
   always_comb begin
      w_state_nxt = r_state;
      w_mcand_nxt = r_mcand;
      w_p_nxt     = r_p;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (in_valid) begin
               w_mcand_nxt = a;
               w_p_nxt     = {WIDTH'(0), b};
               w_cnt_nxt   = '0;
               w_state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            w_p_nxt   = {w_cout, w_sum, r_p[WIDTH-1:1]};
            w_cnt_nxt = r_cnt + CNT_W'(1);
            if (r_cnt == CNT_W'(WIDTH - 1)) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign product   = r_p;

endmodule

// File: tb/tb_mul6_shift_add.sv
// Scoreboard bench for mul6_shift_add: directed vectors plus a stalled random run.
module tb_mul6_shift_add;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [5:0]  a;
   logic [5:0]  b;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] product;

   int checks = 0;
   int errors = 0;
   int exp_q[$];
   bit drv_done;

   mul6_shift_add dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: a transfer completes at the posedge following a negedge with valid&ready
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0d expected=none @%0t", product, $time);
         end else begin
            check("product", int'(product), exp_q.pop_front());
         end
      end
   end

   // Presents operands until accepted; returns #1 after the acceptance edge
   task automatic send(input logic [5:0] ta, input logic [5:0] tb_v, input int exp);
      int n;
      a        = ta;
      b        = tb_v;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 300) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) check("accept_timeout", 0, 1);
      exp_q.push_back(exp);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   // Counts negedges from acceptance until out_valid rises
   task automatic expect_latency(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!out_valid && n < 20) begin
         n++;
         @(negedge clk);
      end
      check(name, n, 6);
   endtask

   task automatic finish_op();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int dir_a[4] = '{42, 1, 63, 1};
      int dir_b[4] = '{21, 1, 1, 63};
      int dir_p[4] = '{882, 1, 63, 63};
      int n;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; drv_done = 1'b0;
      #12;
      check("rst_in_ready",  int'(in_ready),  1);
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_product",   int'(product),   0);
      @(posedge clk); #1 rst_n = 1'b1;

      // Max operands, with cycle-accurate latency and busy in_ready
      send(6'd63, 6'd63, 3969);
      check("busy_in_ready", int'(in_ready), 0);
      expect_latency("lat_63x63");
      finish_op();

      // Zero operands still run the full iteration count
      send(6'd0, 6'd45, 0);
      expect_latency("lat_0x45");
      finish_op();
      send(6'd45, 6'd0, 0);
      expect_latency("lat_45x0");
      finish_op();

      for (int i = 0; i < 4; i++) begin
         send(6'(dir_a[i]), 6'(dir_b[i]), dir_p[i]);
         expect_latency("lat_dir");
         finish_op();
      end

      // Back-pressure in DONE while new operands wait on the input side
      out_ready = 1'b0;
      send(6'd5, 6'd6, 30);
      expect_latency("lat_5x6");
      @(posedge clk); #1;
      a = 6'd9; b = 6'd7; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("hold_out_valid", int'(out_valid), 1);
         check("hold_in_ready",  int'(in_ready),  0);
         check("hold_product",   int'(product),   30);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      check("done_exit_in_ready", int'(in_ready), 0);
      @(negedge clk);
      check("idle_in_ready", int'(in_ready), 1);
      exp_q.push_back(63);
      @(posedge clk); #1 in_valid = 1'b0;
      expect_latency("lat_9x7");
      finish_op();

      // Reset in the third RUN cycle discards the operation
      send(6'd50, 6'd50, 2500);
      @(posedge clk);
      @(posedge clk); #1 rst_n = 1'b0;
      #1;
      check("abort_product",   int'(product),   0);
      check("abort_out_valid", int'(out_valid), 0);
      check("abort_in_ready",  int'(in_ready),  1);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      send(6'd7, 6'd9, 63);
      expect_latency("lat_7x9");
      finish_op();

      // Random operands with random input gaps and output stalls
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               logic [5:0] ra, rb;
               ra = 6'($urandom_range(0, 63));
               rb = 6'($urandom_range(0, 63));
               repeat ($urandom_range(0, 3)) @(posedge clk);
               #1;
               send(ra, rb, int'(ra) * int'(rb));
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join

      out_ready = 1'b1;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         n++;
         @(posedge clk);
      end
      #1;
      check("drain_queue_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
